// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - step-period cfg handshake and pattern table write bus
interface led_pattern_sequencer_if #(
    parameter int DIV_W    = 20,
    parameter int NUM_LEDS = 4,
    parameter int AW       = 3
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [DIV_W-1:0]    cfg_div;
    logic                pat_we;
    logic [AW-1:0]       pat_addr;
    logic [NUM_LEDS-1:0] pat_data;

    modport master (
        output cfg_valid, cfg_div, pat_we, pat_addr, pat_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_div, pat_we, pat_addr, pat_data,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - tick-enable LED pattern sequencer with shadowed step period
module led_pattern_sequencer #(
    parameter int DIV_W       = 20,
    parameter int DEFAULT_DIV = 500000,
    parameter int NUM_LEDS    = 4,
    parameter int PAT_DEPTH   = 8,
    parameter int AW          = 3
) (
    input  logic                 clk_in,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [AW-1:0]        pat_len,
    led_pattern_sequencer_if.slave bus,
    output logic [NUM_LEDS-1:0]  led,
    output logic                 tick,
    output logic [AW-1:0]        step_idx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW-1:0]    IDX0 = '0;
    localparam logic [DIV_W-1:0] DIV1 = DIV_W'(1);

    state_t              state;
    logic [NUM_LEDS-1:0] mem [PAT_DEPTH];
    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    div_active;
    logic [DIV_W-1:0]    shadow;
    logic                cfg_pend;
    logic                cfg_ret;
    logic                cfg_ready_q;
    logic [AW-1:0]       len_q;

    assign bus.cfg_ready = cfg_ready_q;

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            led         <= '0;
            tick        <= 1'b0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
            div_active  <= DIV_W'(DEFAULT_DIV);
            shadow      <= DIV1;
            cfg_pend    <= 1'b0;
            cfg_ret     <= 1'b0;
            cfg_ready_q <= 1'b1;
            len_q       <= '0;
            for (int i = 0; i < PAT_DEPTH; i++) mem[i] <= '0;
        end else begin
            tick <= 1'b0;
            if (bus.pat_we) mem[bus.pat_addr] <= bus.pat_data;

            // cfg_ready is freed one cycle after the shadow reaches div_active
            if (cfg_ret) begin
                cfg_ready_q <= 1'b1;
                cfg_ret     <= 1'b0;
            end
            if (bus.cfg_valid && cfg_ready_q) begin
                shadow      <= (bus.cfg_div == '0) ? DIV1 : bus.cfg_div;
                cfg_pend    <= 1'b1;
                cfg_ready_q <= 1'b0;
            end
            if (cfg_pend && state != RUN) begin
                div_active <= shadow;
                cfg_pend   <= 1'b0;
                cfg_ret    <= 1'b1;
            end

            if (stop) begin
                state    <= IDLE;
                led      <= '0;
                step_idx <= '0;
                busy     <= 1'b0;
                done     <= 1'b0;
                cnt      <= '0;
                if (state == RUN && cfg_pend) begin
                    cfg_pend    <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            end else if (start) begin
                state    <= RUN;
                step_idx <= IDX0;
                led      <= mem[IDX0];
                tick     <= 1'b1;
                len_q    <= pat_len;
                cnt      <= '0;
                busy     <= 1'b1;
                done     <= 1'b0;
            end else if (state == RUN) begin
                if (cnt == div_active - DIV1) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    // a pending period takes effect only from the new step on
                    if (cfg_pend) begin
                        div_active <= shadow;
                        cfg_pend   <= 1'b0;
                        cfg_ret    <= 1'b1;
                    end
                    if (step_idx < len_q) begin
                        step_idx <= step_idx + AW'(1);
                        led      <= mem[step_idx + AW'(1)];
                    end else if (loop_en) begin
                        step_idx <= IDX0;
                        led      <= mem[IDX0];
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + DIV1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - directed self-checking bench for led_pattern_sequencer
module tb_led_pattern_sequencer;

    logic       clk_in;
    logic       rstn;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [2:0] pat_len;
    logic [3:0] led;
    logic       tick;
    logic [2:0] step_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int pat  [4] = '{1, 2, 4, 8};
    int e3_led  [11] = '{1, 1, 1, 1, 2, 2, 4, 4, 8, 8, 1};
    int e3_tick [11] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1};
    int e3_rdy  [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int e6_led  [16] = '{1, 1, 1, 1, 2, 2, 2, 2, 15, 15, 15, 15, 8, 8, 8, 8};

    led_pattern_sequencer_if #(.DIV_W(20), .NUM_LEDS(4), .AW(3)) bus ();

    led_pattern_sequencer #(
        .DIV_W(20), .DEFAULT_DIV(4), .NUM_LEDS(4), .PAT_DEPTH(8), .AW(3)
    ) dut (
        .clk_in(clk_in), .rstn(rstn), .start(start), .stop(stop),
        .loop_en(loop_en), .pat_len(pat_len), .bus(bus),
        .led(led), .tick(tick), .step_idx(step_idx), .busy(busy), .done(done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic write_tab(input logic [2:0] a, input logic [3:0] d);
        bus.pat_we   = 1'b1;
        bus.pat_addr = a;
        bus.pat_data = d;
        @(negedge clk_in);
        bus.pat_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_in);
        #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk_in);
        #1 stop = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 4; i++) write_tab(3'(i), 4'(pat[i]));
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; pat_len = 3'd3;
        bus.cfg_valid = 1'b0; bus.cfg_div = '0;
        bus.pat_we = 1'b0; bus.pat_addr = '0; bus.pat_data = '0;
        repeat (2) @(negedge clk_in);
        check("rst_led", led, 0);
        check("rst_tick", tick, 0);
        check("rst_idx", step_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdy", bus.cfg_ready, 1);
        rstn = 1'b1;
        @(negedge clk_in);
        load_table();

        // one-shot run, 4 cycles per step
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_in);
            check("t1_led", led, pat[k/4]);
            check("t1_tick", tick, (k % 4 == 0) ? 1 : 0);
            check("t1_idx", step_idx, k / 4);
            check("t1_busy", busy, 1);
        end
        @(negedge clk_in);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_led_end", led, 8);
        @(negedge clk_in);
        check("t1_led_hold", led, 8);
        check("t1_idx_hold", step_idx, 3);

        // looping run started from DONE
        loop_en = 1'b1;
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            check("t2_led", led, pat[(k/4) % 4]);
            check("t2_idx", step_idx, (k/4) % 4);
            check("t2_busy", busy, 1);
        end
        start = 1'b1; stop = 1'b1;
        @(posedge clk_in);
        #1 begin start = 1'b0; stop = 1'b0; end
        @(negedge clk_in);
        check("t5_led", led, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);

        // period change mid-step
        pulse_start();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk_in);
            check("t3_led", led, e3_led[k]);
            check("t3_tick", tick, e3_tick[k]);
            check("t3_rdy", bus.cfg_ready, e3_rdy[k]);
            if (k == 1) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_div   = 20'd2;
            end
            if (k == 2) bus.cfg_valid = 1'b0;
        end
        pulse_stop();

        // divisor 0 treated as 1
        @(negedge clk_in);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = '0;
        @(negedge clk_in);
        check("t4_rdy0", bus.cfg_ready, 0);
        bus.cfg_valid = 1'b0;
        @(negedge clk_in);
        check("t4_rdy1", bus.cfg_ready, 0);
        @(negedge clk_in);
        check("t4_rdy2", bus.cfg_ready, 1);
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            check("t4_led", led, pat[k % 4]);
            check("t4_tick", tick, 1);
            check("t4_idx", step_idx, k % 4);
        end

        // asynchronous reset mid-run
        @(negedge clk_in);
        #2 rstn = 1'b0;
        #1;
        check("t5_arst_led", led, 0);
        check("t5_arst_busy", busy, 0);
        check("t5_arst_tick", tick, 0);
        check("t5_arst_idx", step_idx, 0);
        @(negedge clk_in);
        rstn = 1'b1;
        pulse_start();
        @(negedge clk_in);
        check("t5_tab_clr", led, 0);
        check("t5_rst_busy", busy, 1);
        pulse_stop();

        // table writes during a run, pat_len change ignored
        @(negedge clk_in);
        loop_en = 1'b0;
        load_table();
        pulse_start();
        pat_len = 3'd1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_in);
            check("t6_led", led, e6_led[k]);
            if (k == 5) write_tab_nowait(3'd2, 4'hF);
            if (k == 6) write_tab_nowait(3'd1, 4'h7);
            if (k == 7) bus.pat_we = 1'b0;
        end
        @(negedge clk_in);
        check("t6_done", done, 1);
        check("t6_led_end", led, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic write_tab_nowait(input logic [2:0] a, input logic [3:0] d);
        bus.pat_we   = 1'b1;
        bus.pat_addr = a;
        bus.pat_data = d;
    endtask

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Sequences a programmable LED pattern table at a programmable step rate on the fabric clock. It replaces the free-running toggle divider with a single-clock-domain tick-enable counter, so no derived clocks are produced. A cfg valid/ready handshake accepts step-period changes, which take effect only at step boundaries. Sits between the fabric control registers and the board LED pins.

Parameters:
DIV_W, 20, width of the step-period counter and divisor.
DEFAULT_DIV, 500000, step period in clk_in cycles after reset (1 MHz clock gives 0.5 s).
NUM_LEDS, 4, LED output width.
PAT_DEPTH, 8, pattern table entries; power of 2.
AW, 3, log2(PAT_DEPTH).

Ports:
clk_in  input  1  fabric clock; all logic on the rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  level/pulse; begin or restart the sequence from entry 0.
stop  input  1  abort to IDLE.
loop_en  input  1  1: wrap after last entry; 0: finish in DONE.
pat_len  input  AW  index of last valid entry; sampled on the start edge.
pat_we  input  1  pattern table write strobe.
pat_addr  input  AW  table write address.
pat_data  input  NUM_LEDS  table write data.
cfg_valid  input  1  new divisor offered.
cfg_ready  output  1  divisor shadow register free.
cfg_div  input  DIV_W  new step period in cycles; 0 is treated as 1.
led  output  NUM_LEDS  current pattern entry.
tick  output  1  one-cycle pulse in the first cycle of each new step.
step_idx  output  AW  index currently driven on led.
busy  output  1  high in RUN.
done  output  1  high in DONE.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE; led=0, tick=0, step_idx=0, busy=0, done=0.
  - cfg_ready=1; active divisor=DEFAULT_DIV; counter=0.
  - Pattern table cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE: led=0, counter held at 0.
  - start=1 -> RUN at next edge: step_idx=0, led=table[0], tick=1, latched length=pat_len.
- RUN: busy=1; counter increments each cycle. When counter==div_active-1:
  - counter<=0, tick<=1.
  - If step_idx<latched length: step_idx+1, led=table[step_idx+1].
  - Else if loop_en=1: step_idx=0, led=table[0].
  - Else: go to DONE.
  - Result: each step lasts exactly div_active cycles; tick is registered and coincides with the first cycle of the new led value.
- DONE: done=1, busy=0; led and step_idx hold the last entry.
  - start -> RUN as from IDLE.
  - stop -> IDLE.
- Priority: stop beats start in any state. stop in RUN -> IDLE next edge, led=0, and any pending cfg is discarded. start in RUN restarts at entry 0 and clears counter.
- loop_en is sampled only at the final-step boundary. pat_len changes after start are ignored until the next start.
- Cfg handshake:
  - A transfer occurs when cfg_valid && cfg_ready; the value is captured into a shadow register and cfg_ready drops next cycle.
  - In IDLE/DONE the shadow is applied to div_active on the following edge and cfg_ready returns to 1 one cycle later.
  - In RUN the shadow is applied only at a step boundary, together with tick; the step in progress completes at the old period, and cfg_ready returns high the cycle after.
  - cfg_div=0 is stored as 1, which gives a step change every cycle; tick then stays high continuously.
- Table writes: pat_we writes table[pat_addr] at the edge in any state. The entry is visible on led only when that index is next loaded; the current led value is not updated. A write and a load of the same address in the same cycle loads the old data.
- Counter compare uses full DIV_W width with no overflow; div_active is never 0.

Test Plan:
- Reset, then DEFAULT_DIV overridden to 4; table {1,2,4,8}; pat_len=3, loop_en=0; pulse start -> led 1,2,4,8 each for exactly 4 cycles, tick on each change; then DONE with done=1 and led=8 held.
- Same setup with loop_en=1 -> after 8 the sequence wraps to led=1; step_idx reads 0,1,2,3,0; busy stays 1.
- In RUN with div=4, handshake cfg_div=2 mid-step -> cfg_ready low; current step stays 4 cycles, the following steps are 2 cycles; cfg_ready returns high one cycle after the boundary.
- cfg_div=0 in IDLE, then start -> led changes every cycle and tick stays high continuously.
- start and stop asserted together in RUN -> IDLE, led=0, busy=0. rstn dropped mid-RUN -> outputs return to reset values immediately, with no clock edge.
- pat_we to entry 2 with value 0xF while step 1 is showing -> next step shows 0xF; writing entry 1 during step 1 leaves led unchanged.
